rco_event_capture: RTL and testbench
====================================

# rco_event_capture

Downstream monitor for `counter32b`. Samples the counter's `RCO` and `LOAD` strobes, together with `Q` and `MODO`, on every enabled cycle, and timestamps each event. Events are buffered in a small FIFO and drained through a valid/ready port to the log/checker side. The block also keeps a saturating wrap-around tally, so long counter runs can be summarised without reading every event.

## Interface
Parameters:
- `WIDTH`, 32: width of `Q` and `EV_Q`; must match the counter width.
- `TS_WIDTH`, 16: width of the free-running timestamp.
- `DEPTH`, 4: number of FIFO entries; must be a power of two, ≥ 2.

Ports:
- `CLK`  in  1  single clock; all logic on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `ENABLE`  in  1  same enable that drives the counter; events are sampled only while it is 1.
- `RCO`  in  1  counter ripple-carry-out strobe.
- `LOAD`  in  1  counter load strobe.
- `Q`  in  WIDTH  counter output value.
- `MODO`  in  2  counter mode.
- `EV_VALID`  out  1  FIFO head entry is valid.
- `EV_READY`  in  1  consumer accepts the head entry.
- `EV_KIND`  out  2  head event kind: bit0 = RCO, bit1 = LOAD.
- `EV_TS`  out  TS_WIDTH  head timestamp.
- `EV_Q`  out  WIDTH  `Q` captured with the head event.
- `EV_MODO`  out  2  `MODO` captured with the head event.
- `RCO_COUNT`  out  16  total enabled RCO strobes, saturating.
- `LEVEL`  out  clog2(DEPTH)+1  current FIFO occupancy.
- `DROP`  out  1  sticky: at least one event was lost because the FIFO was full.

## Operation
- **Timestamp counter `ts`:**
  - Cleared by `RESET`.
  - Increments every cycle, independent of `ENABLE`.
  - Wraps modulo 2^TS_WIDTH.
- **Event condition:** `ev = ENABLE & (RCO | LOAD)`.
  - One entry per event cycle; simultaneous RCO and LOAD produce one entry with `EV_KIND` = 2'b11.
- **Entry contents:** {`RCO`, `LOAD`} → `EV_KIND`, plus `ts`, `Q` and `MODO`, all sampled in the same cycle.
- **Push:** occurs when `ev` is 1 and the FIFO is not full.
  - Also occurs when the FIFO is full and a pop happens in the same cycle; the FIFO stays full and the oldest entry is replaced in order.
- **Pop:** occurs when `EV_VALID & EV_READY`.
- **Drop:** when `ev` is 1, the FIFO is full and there is no pop:
  - the entry is discarded;
  - `DROP` is set to 1 and holds until `RESET`;
  - `LEVEL` is unchanged.
- **Empty FIFO:**
  - `EV_VALID` = 0.
  - `EV_*` data holds its last value (don't-care to the consumer).
  - `EV_READY` is ignored.
- **Simultaneous push and pop on a non-empty FIFO:** `LEVEL` is unchanged.
- **Ordering:** strict FIFO; read and write pointers wrap modulo DEPTH.
- **`RCO_COUNT`:**
  - Increments on `ENABLE & RCO`, independent of FIFO state or drops.
  - Saturates at 0xFFFF.
- **Inputs with `ENABLE` = 0:** `RCO` and `LOAD` are ignored entirely; no entry is pushed and no count is taken.
- **Storage:** plain register array; no memory macro.

## Timing
- **Reset:** `RESET` = 1 at an edge clears every output. After that edge:
  - `EV_VALID`=0, `EV_KIND`=0, `EV_TS`=0, `EV_Q`=0, `EV_MODO`=0;
  - `RCO_COUNT`=0, `LEVEL`=0, `DROP`=0;
  - `ts`=0 and the FIFO pointers are 0.
- **Reset mid-operation:** all entries are discarded and a pending handshake is cancelled. An event in the reset cycle is not captured.
- **Timestamp after reset:** the first cycle after reset deasserts samples `ts`=0, the next samples 1, and so on.
- **Push-to-output latency:** an event sampled at edge N appears at the outputs after edge N. If the FIFO was empty, `EV_VALID`=1 in the cycle following the event cycle; there is no combinational path from inputs to `EV_*`.
- **Head outputs:** `EV_*` come from the head register and pointer (show-ahead). After a pop at edge N, the next entry is presented in the cycle after edge N.
- **`RCO_COUNT`, `LEVEL` and `DROP`:** update at the same edge as the triggering event; they are registered outputs.
- **Throughput:** one push and one pop per cycle, sustained.

## Test plan
- **Reset values:** hold `RESET` 3 cycles with `RCO`=`LOAD`=1 and `ENABLE`=1 → every output is 0 and no entry is captured. Release reset, then pulse `RCO` in the 6th cycle → `EV_VALID`=1 the next cycle, `EV_KIND`=01, `EV_TS`=5, `RCO_COUNT`=1.
- **Coincident strobes:** `LOAD`=`RCO`=1 in the same cycle with `Q`=0xDEADBEEF, `MODO`=11 → one entry: `EV_KIND`=11, `EV_Q`=0xDEADBEEF, `EV_MODO`=3; `LEVEL`=1.
- **Full and drop:** `EV_READY`=0, then 5 consecutive RCO events with `DEPTH`=4 → `LEVEL`=4, `DROP`=1, `RCO_COUNT`=5. Then drain → 4 entries with consecutive `EV_TS` values; the 5th event is absent.
- **Full with concurrent pop:** FIFO full and `EV_READY`=1 while an event arrives every cycle for 8 cycles → `LEVEL` stays 4, `DROP` stays 0, output order is intact.
- **Enable gating and saturation:**
  - `ENABLE`=0 with RCO toggling for 10 cycles → no entries and `RCO_COUNT` unchanged.
  - Force 70000 enabled RCO pulses → `RCO_COUNT`=0xFFFF.
- **Reset mid-drain:** FIFO holds 3 entries; assert `RESET` while `EV_VALID`=`EV_READY`=1 → after the edge `LEVEL`=0, `EV_VALID`=0 and `DROP`=0.

Source files
------------

// File: rtl/rco_event_capture.sv
// Event monitor for counter32b: timestamps enabled RCO/LOAD strobes into a small
// show-ahead FIFO drained over valid/ready, plus a saturating RCO tally.
module rco_event_capture #(
  parameter int WIDTH    = 32,
  parameter int TS_WIDTH = 16,
  parameter int DEPTH    = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     ENABLE,
  input  logic                     RCO,
  input  logic                     LOAD,
  input  logic [WIDTH-1:0]         Q,
  input  logic [1:0]               MODO,
  output logic                     EV_VALID,
  input  logic                     EV_READY,
  output logic [1:0]               EV_KIND,
  output logic [TS_WIDTH-1:0]      EV_TS,
  output logic [WIDTH-1:0]         EV_Q,
  output logic [1:0]               EV_MODO,
  output logic [15:0]              RCO_COUNT,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     DROP
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [TS_WIDTH-1:0] ts_q;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic                drop_q;
  logic [15:0]         rco_cnt_q;

  logic [1:0]          mem_kind_q [DEPTH];
  logic [TS_WIDTH-1:0] mem_ts_q   [DEPTH];
  logic [WIDTH-1:0]    mem_q_q    [DEPTH];
  logic [1:0]          mem_modo_q [DEPTH];

  logic [1:0]          hd_kind_q, hd_kind_d;
  logic [TS_WIDTH-1:0] hd_ts_q, hd_ts_d;
  logic [WIDTH-1:0]    hd_q_q, hd_q_d;
  logic [1:0]          hd_modo_q, hd_modo_d;

  logic ev, full, push, pop;

  assign ev   = ENABLE & (RCO | LOAD);
  assign full = (level_q == LW'(DEPTH));
  assign pop  = (level_q != '0) & EV_READY;
  // A full FIFO still accepts an event when the head leaves in the same cycle.
  assign push = ev & (~full | pop);

  assign wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Next head: the incoming event bypasses storage when it lands in the head slot.
  always_comb begin
    hd_kind_d = mem_kind_q[rd_ptr_d];
    hd_ts_d   = mem_ts_q[rd_ptr_d];
    hd_q_d    = mem_q_q[rd_ptr_d];
    hd_modo_d = mem_modo_q[rd_ptr_d];
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      hd_kind_d = {LOAD, RCO};
      hd_ts_d   = ts_q;
      hd_q_d    = Q;
      hd_modo_d = MODO;
    end
  end

  // Capture stage: control state and head registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ts_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      drop_q    <= 1'b0;
      rco_cnt_q <= '0;
      hd_kind_q <= '0;
      hd_ts_q   <= '0;
      hd_q_q    <= '0;
      hd_modo_q <= '0;
    end else begin
      ts_q     <= ts_q + TS_WIDTH'(1);
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (ev && full && !pop)
        drop_q <= 1'b1;
      if (ENABLE && RCO)
        rco_cnt_q <= sat_inc16(rco_cnt_q);
      if (level_d != '0) begin
        hd_kind_q <= hd_kind_d;
        hd_ts_q   <= hd_ts_d;
        hd_q_q    <= hd_q_d;
        hd_modo_q <= hd_modo_d;
      end
    end
  end

  // Storage stage: plain register array, written only on push
  always_ff @(posedge CLK) begin
    if (push && !RESET) begin
      mem_kind_q[wr_ptr_q] <= {LOAD, RCO};
      mem_ts_q[wr_ptr_q]   <= ts_q;
      mem_q_q[wr_ptr_q]    <= Q;
      mem_modo_q[wr_ptr_q] <= MODO;
    end
  end

  assign EV_VALID  = (level_q != '0);
  assign EV_KIND   = hd_kind_q;
  assign EV_TS     = hd_ts_q;
  assign EV_Q      = hd_q_q;
  assign EV_MODO   = hd_modo_q;
  assign RCO_COUNT = rco_cnt_q;
  assign LEVEL     = level_q;
  assign DROP      = drop_q;

endmodule

// File: tb/tb_rco_event_capture.sv
// Scoreboard bench for rco_event_capture: queue-based reference model fed by
// directed and random stimulus, with a negedge monitor comparing every cycle.
module tb_rco_event_capture;
  localparam int WIDTH = 32;
  localparam int TSW   = 16;
  localparam int DEPTH = 4;

  logic             CLK, RESET, ENABLE, RCO, LOAD, EV_READY;
  logic [WIDTH-1:0] Q;
  logic [1:0]       MODO;
  logic             EV_VALID, DROP;
  logic [1:0]       EV_KIND, EV_MODO;
  logic [TSW-1:0]   EV_TS;
  logic [WIDTH-1:0] EV_Q;
  logic [15:0]      RCO_COUNT;
  logic [2:0]       LEVEL;

  rco_event_capture #(.WIDTH(WIDTH), .TS_WIDTH(TSW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .RCO(RCO), .LOAD(LOAD),
    .Q(Q), .MODO(MODO), .EV_VALID(EV_VALID), .EV_READY(EV_READY),
    .EV_KIND(EV_KIND), .EV_TS(EV_TS), .EV_Q(EV_Q), .EV_MODO(EV_MODO),
    .RCO_COUNT(RCO_COUNT), .LEVEL(LEVEL), .DROP(DROP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]       kind;
    logic [TSW-1:0]   ts;
    logic [WIDTH-1:0] q;
    logic [1:0]       modo;
  } ent_t;

  ent_t        fifo_m[$];
  ent_t        sb[$];
  logic [15:0] ts_m, cnt_m;
  logic        drop_m;
  int          checks = 0;
  int          errors = 0;
  bit          mon_on = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a bounded queue of whole events.
  always @(posedge CLK) begin : model
    bit   pop_m, ev_m;
    ent_t e;
    if (RESET) begin
      fifo_m.delete();
      sb.delete();
      ts_m   = '0;
      cnt_m  = '0;
      drop_m = 1'b0;
    end else begin
      pop_m = (fifo_m.size() > 0) && EV_READY;
      ev_m  = ENABLE && (RCO || LOAD);
      if (ENABLE && RCO && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
      if (pop_m) void'(fifo_m.pop_front());
      if (ev_m) begin
        if (fifo_m.size() < DEPTH) begin
          e.kind = {LOAD, RCO};
          e.ts   = ts_m;
          e.q    = Q;
          e.modo = MODO;
          fifo_m.push_back(e);
          sb.push_back(e);
        end else begin
          drop_m = 1'b1;
        end
      end
      ts_m = ts_m + 16'd1;
    end
  end

  // Monitor: compares the presented head and status against the model.
  always @(negedge CLK) begin
    if (mon_on) begin
      chk("level", 64'(LEVEL), 64'(fifo_m.size()));
      chk("drop", 64'(DROP), 64'(drop_m));
      chk("rco_count", 64'(RCO_COUNT), 64'(cnt_m));
      chk("ev_valid", 64'(EV_VALID), 64'(fifo_m.size() != 0));
      if (EV_VALID) begin
        chk("head_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          chk("ev_kind", 64'(EV_KIND), 64'(sb[0].kind));
          chk("ev_ts", 64'(EV_TS), 64'(sb[0].ts));
          chk("ev_q", 64'(EV_Q), 64'(sb[0].q));
          chk("ev_modo", 64'(EV_MODO), 64'(sb[0].modo));
          if (EV_READY && !RESET) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; RCO = 1'b0; LOAD = 1'b0; EV_READY = 1'b0; ENABLE = 1'b1;
    step();
    RESET = 1'b0;
  endtask

  task automatic drain();
    RCO = 1'b0; LOAD = 1'b0; EV_READY = 1'b1;
    repeat (DEPTH + 1) step();
    EV_READY = 1'b0;
    chk("drain_level", 64'(LEVEL), 64'd0);
  endtask

  initial begin
    RESET = 1'b1; ENABLE = 1'b1; RCO = 1'b1; LOAD = 1'b1;
    Q = '0; MODO = '0; EV_READY = 1'b0;
    repeat (3) step();
    mon_on = 1;
    chk("rst_valid", 64'(EV_VALID), 0);
    chk("rst_kind", 64'(EV_KIND), 0);
    chk("rst_ts", 64'(EV_TS), 0);
    chk("rst_q", 64'(EV_Q), 0);
    chk("rst_modo", 64'(EV_MODO), 0);
    chk("rst_count", 64'(RCO_COUNT), 0);
    chk("rst_level", 64'(LEVEL), 0);
    chk("rst_drop", 64'(DROP), 0);

    // First event after reset carries timestamp 5.
    RESET = 1'b0; RCO = 1'b0; LOAD = 1'b0;
    repeat (5) step();
    RCO = 1'b1; Q = 32'h1234; MODO = 2'd1;
    step();
    RCO = 1'b0;
    chk("first_valid", 64'(EV_VALID), 1);
    chk("first_kind", 64'(EV_KIND), 64'd1);
    chk("first_ts", 64'(EV_TS), 64'd5);
    chk("first_count", 64'(RCO_COUNT), 64'd1);
    drain();

    // Coincident strobes.
    do_reset();
    RCO = 1'b1; LOAD = 1'b1; Q = 32'hDEADBEEF; MODO = 2'b11;
    step();
    RCO = 1'b0; LOAD = 1'b0;
    chk("coinc_kind", 64'(EV_KIND), 64'd3);
    chk("coinc_q", 64'(EV_Q), 64'hDEADBEEF);
    chk("coinc_modo", 64'(EV_MODO), 64'd3);
    chk("coinc_level", 64'(LEVEL), 64'd1);
    drain();

    // Full and drop.
    do_reset();
    RCO = 1'b1;
    for (int i = 0; i < 5; i++) begin
      Q = 32'(i); step();
    end
    RCO = 1'b0;
    chk("full_level", 64'(LEVEL), 64'd4);
    chk("full_drop", 64'(DROP), 64'd1);
    chk("full_count", 64'(RCO_COUNT), 64'd5);
    chk("full_head_ts", 64'(EV_TS), 64'd0);
    drain();

    // Full with concurrent pop.
    do_reset();
    RCO = 1'b1;
    repeat (4) step();
    EV_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      Q = 32'(100 + i); step();
      chk("fullpop_level", 64'(LEVEL), 64'd4);
      chk("fullpop_drop", 64'(DROP), 64'd0);
    end
    drain();

    // Enable gating.
    do_reset();
    ENABLE = 1'b0;
    for (int i = 0; i < 10; i++) begin
      RCO = i[0]; LOAD = ~i[0]; step();
    end
    chk("gate_level", 64'(LEVEL), 64'd0);
    chk("gate_count", 64'(RCO_COUNT), 64'd0);
    ENABLE = 1'b1; RCO = 1'b0; LOAD = 1'b0;

    // Reset mid-drain.
    do_reset();
    RCO = 1'b1;
    repeat (3) step();
    RCO = 1'b0;
    chk("mid_level3", 64'(LEVEL), 64'd3);
    EV_READY = 1'b1; RESET = 1'b1;
    step();
    RESET = 1'b0; EV_READY = 1'b0;
    chk("mid_level", 64'(LEVEL), 64'd0);
    chk("mid_valid", 64'(EV_VALID), 64'd0);
    chk("mid_drop", 64'(DROP), 64'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      ENABLE   = ($urandom_range(0, 3) != 0);
      RCO      = ($urandom_range(0, 2) == 0);
      LOAD     = ($urandom_range(0, 3) == 0);
      Q        = $urandom;
      MODO     = 2'($urandom_range(0, 3));
      EV_READY = $urandom_range(0, 1);
      RESET    = ($urandom_range(0, 249) == 0);
      step();
    end
    RESET = 1'b0;

    // Saturation of the RCO tally (also wraps the timestamp).
    do_reset();
    RCO = 1'b1; LOAD = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      EV_READY = $urandom_range(0, 1);
      Q = $urandom;
      step();
    end
    RCO = 1'b0;
    chk("sat_count", 64'(RCO_COUNT), 64'hFFFF);
    drain();
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
